freq_frame_tx: RTL and testbench



---
 rtl/freq_frame_tx.sv | 153 +++++++++++++++
 tb/tb_freq_frame_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/freq_frame_tx.sv
// Frequency-set link transmitter: frames a 28-bit word as START, B0..B3, END
// and shifts each byte out as 8N1 UART, LSB first.
module freq_frame_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  START_BYTE   = 8'hFF,
  parameter logic [7:0]  END_BYTE     = 8'hFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] freq_in,
  input  logic        send_req,
  output logic        busy,
  output logic        done,
  output logic        reject,
  output logic        tx
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bitIdx;
  logic [2:0]       r_byteIdx;
  logic [27:0]      r_freq;
  logic             r_busy;
  logic             r_done;
  logic             r_reject;
  logic             r_tx;

  logic [7:0]       w_curByte;
  logic [2:0]       w_nextBit;
  logic             w_baudLast;
  logic             w_valid;

  // A data byte equal to END_BYTE would terminate the frame early at the receiver.
  assign w_valid = ({4'h0, freq_in[27:24]} != END_BYTE) &&
                   (freq_in[23:16] != END_BYTE) &&
                   (freq_in[15:8]  != END_BYTE) &&
                   (freq_in[7:0]   != END_BYTE);

  assign w_baudLast = (r_baud == BAUD_LAST);
  assign w_nextBit  = r_bitIdx + 3'd1;

  always_comb begin
    w_curByte = END_BYTE;
    case (r_byteIdx)
      3'd0:    w_curByte = START_BYTE;
      3'd1:    w_curByte = {4'h0, r_freq[27:24]};
      3'd2:    w_curByte = r_freq[23:16];
      3'd3:    w_curByte = r_freq[15:8];
      3'd4:    w_curByte = r_freq[7:0];
      default: w_curByte = END_BYTE;
    endcase
  end

  // tx is loaded one cycle ahead of each bit boundary so the pin is a plain flop output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bitIdx  <= '0;
      r_byteIdx <= '0;
      r_freq    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_reject  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_done   <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (send_req) begin
            r_freq <= freq_in;
            if (w_valid) begin
              r_state   <= S_START;
              r_baud    <= '0;
              r_byteIdx <= '0;
              r_busy    <= 1'b1;
              r_tx      <= 1'b0;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_START: begin
          if (w_baudLast) begin
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_state  <= S_DATA;
            r_tx     <= w_curByte[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baudLast) begin
            r_baud <= '0;
            if (r_bitIdx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitIdx <= w_nextBit;
              r_tx     <= w_curByte[w_nextBit];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baudLast) begin
            r_baud <= '0;
            if (r_byteIdx == 3'd5) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_tx    <= 1'b1;
            end else begin
              r_byteIdx <= r_byteIdx + 3'd1;
              r_state   <= S_START;
              r_tx      <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_byteIdx <= '0;
          r_bitIdx  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign reject = r_reject;
  assign tx     = r_tx;

endmodule

// File: tb/tb_freq_frame_tx.sv
// Self-checking bench for freq_frame_tx; expected line levels come from a
// byte/bit-position model of the frame rather than from the RTL structure.
module tb_freq_frame_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 60 * CPB;

  logic        clk;
  logic        rst_n;
  logic [27:0] freq_in;
  logic        send_req;
  logic        busy;
  logic        done;
  logic        reject;
  logic        tx;

  int checks = 0;
  int errors = 0;

  freq_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .freq_in  (freq_in),
    .send_req (send_req),
    .busy     (busy),
    .done     (done),
    .reject   (reject),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] frameByte(input logic [27:0] f, input int idx);
    logic [7:0] bytes [6];
    bytes[0] = 8'hFF;
    bytes[1] = {4'h0, f[27:24]};
    bytes[2] = f[23:16];
    bytes[3] = f[15:8];
    bytes[4] = f[7:0];
    bytes[5] = 8'hFE;
    return bytes[idx];
  endfunction

  function automatic bit isSendable(input logic [27:0] f);
    for (int i = 1; i <= 4; i++)
      if (frameByte(f, i) == 8'hFE) return 1'b0;
    return 1'b1;
  endfunction

  // Line level k cycles into the frame: 10-bit UART characters, start=0, stop=1.
  function automatic logic expectedTx(input logic [27:0] f, input int k);
    int bitNum;
    int pos;
    logic [7:0] b;
    bitNum = k / CPB;
    pos    = bitNum % 10;
    b      = frameByte(f, bitNum / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, ".tx"},     tx,     1'b1);
    checkOutput({tag, ".busy"},   busy,   1'b0);
    checkOutput({tag, ".done"},   done,   1'b0);
    checkOutput({tag, ".reject"}, reject, 1'b0);
  endtask

  // Called at the start of cycle N; returns at the start of the cycle after done
  // (valid word) or a few cycles after the reject pulse (unsendable word).
  task automatic applyStimulus(input logic [27:0] f, input bit noiseMid, input bit reqInDone);
    freq_in  = f;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    if (!isSendable(f)) begin
      @(negedge clk);
      checkOutput("rej.pulse", reject, 1'b1);
      checkOutput("rej.busy",  busy,   1'b0);
      checkOutput("rej.tx",    tx,     1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
        checkIdle($sformatf("rej.after%0d", i));
        tick();
      end
      return;
    end
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (noiseMid && k == 100) begin
        send_req = 1'b1;
        freq_in  = 28'($urandom);
      end else if (noiseMid && k == 101) begin
        send_req = 1'b0;
      end else if (noiseMid && k == 150) begin
        freq_in = 28'($urandom);
      end
      @(negedge clk);
      checkOutput($sformatf("frm.tx@%0d", k),   tx,     expectedTx(f, k));
      checkOutput($sformatf("frm.busy@%0d", k), busy,   1'b1);
      checkOutput($sformatf("frm.done@%0d", k), done,   1'b0);
      checkOutput($sformatf("frm.rej@%0d", k),  reject, 1'b0);
      tick();
    end
    if (reqInDone) begin
      send_req = 1'b1;
      freq_in  = 28'h0ABCDEF;
    end
    @(negedge clk);
    checkOutput("end.done", done, 1'b1);
    checkOutput("end.busy", busy, 1'b0);
    checkOutput("end.tx",   tx,   1'b1);
    tick();
    send_req = 1'b0;
    @(negedge clk);
    checkOutput("post.busy", busy, 1'b0);
    checkOutput("post.done", done, 1'b0);
    checkOutput("post.tx",   tx,   1'b1);
    #1;
  endtask

  initial begin
    logic [27:0] f;
    bit          sawActivity;

    rst_n    = 1'b0;
    send_req = 1'b0;
    freq_in  = '0;
    tick();
    tick();
    checkIdle("reset");
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      checkIdle($sformatf("idle%0d", i));
      tick();
    end

    applyStimulus(28'h1234567, 1'b0, 1'b0);
    applyStimulus(28'hFFFFFFF, 1'b0, 1'b0);
    applyStimulus(28'h0FE0000, 1'b0, 1'b0);
    applyStimulus(28'h00FE000, 1'b0, 1'b0);
    applyStimulus(28'h00000FE, 1'b0, 1'b0);

    // Ignored mid-frame request, then a request in the done cycle, then one at done+1.
    applyStimulus(28'h0A5C3E1, 1'b1, 1'b1);
    applyStimulus(28'h0000000, 1'b0, 1'b0);

    // Reset one cycle during a data bit of B2.
    freq_in  = 28'h3C0FFEE;
    send_req = 1'b1;
    tick();
    send_req = 1'b0;
    for (int k = 0; k < 3 * 10 * CPB + 3 * CPB + 1; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstmid.tx",   tx,   1'b1);
    checkOutput("rstmid.busy", busy, 1'b0);
    checkOutput("rstmid.done", done, 1'b0);
    #1;
    sawActivity = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (done || busy || !tx) sawActivity = 1'b1;
      #1;
    end
    checkOutput("rstmid.quiet", sawActivity, 1'b0);
    tick();
    applyStimulus(28'h3C0FFEE, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      f = 28'($urandom);
      if (r == 2) f[15:8] = 8'hFE;
      applyStimulus(f, r[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
